// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, reply bytes and FSM state type for the UART command responder.
// Build option: UART_CMD_CHECKSUM_EN adds the GET_CSUM state.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
`ifdef UART_CMD_CHECKSUM_EN
        GET_CSUM,
`endif
        EXEC,
        SEND,
        SEND_WAIT
    } state_e;

endpackage

// File: rtl/uart_cmd_regbank.sv
// NREGS x 8-bit register bank: synchronous write port, combinational read port,
// cleared by synchronous active-low reset.
module uart_cmd_regbank #(
    parameter int NREGS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/uart_cmd_responder.sv
// Device-side command responder: parses 'W'/'R' frames from the UART receiver,
// accesses the register bank and returns one reply byte. Build option: UART_CMD_CHECKSUM_EN.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int NREGS          = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_clr,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [2:0] fsm_state
);

    localparam int             TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]     NREGS_LIM = 9'(NREGS);

    // Handshakes: a byte is taken when rx_rdy=1 and rx_clr was low last cycle;
    // rx_clr pulses once per taken byte. tx_wr pulses once per reply with tx_data held.
    state_e        state;
    logic [TW-1:0] tmo_cnt;
    logic          is_wr;
    logic [7:0]    addr_q;
    logic          wait_first;
    logic          rx_window;
    logic          accept;
    logic          addr_ok;
    logic          frame_err;
    logic [7:0]    rd_data;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]    csum_q;
    logic [7:0]    data_q;
    logic          csum_bad_q;
`endif

    always_comb begin
        rx_window = 1'b0;
        case (state)
            IDLE, GET_ADDR, GET_DATA: rx_window = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
            GET_CSUM:                 rx_window = 1'b1;
`endif
            default:                  rx_window = 1'b0;
        endcase
    end

    assign accept    = rx_rdy && !rx_clr && rx_window;
    assign addr_ok   = ({1'b0, addr_q} < NREGS_LIM);
`ifdef UART_CMD_CHECKSUM_EN
    assign frame_err = !addr_ok || csum_bad_q;
`else
    assign frame_err = !addr_ok;
`endif
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    uart_cmd_regbank #(.NREGS(NREGS)) u_regbank (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .we    (wr_stb),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (addr_q[3:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            is_wr      <= 1'b0;
            addr_q     <= 8'h00;
            wait_first <= 1'b0;
            rx_clr     <= 1'b0;
            tx_data    <= 8'h00;
            tx_wr      <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 4'h0;
            wr_data    <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q     <= 8'h00;
            data_q     <= 8'h00;
            csum_bad_q <= 1'b0;
`endif
        end else begin
            rx_clr <= accept;
            wr_stb <= 1'b0;

            // Inter-byte timer only runs while waiting for the rest of a frame.
            if (accept || state == IDLE || !rx_window) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef UART_CMD_CHECKSUM_EN
                        csum_q <= rx_data;
`endif
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            is_wr <= (rx_data == CMD_WR);
                            state <= GET_ADDR;
                        end else begin
                            tx_data <= RSP_ERR;
                            tx_wr   <= !tx_busy;
                            state   <= SEND;
                        end
                    end
                end
                GET_ADDR: begin
                    if (accept) begin
                        addr_q <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
                        state  <= is_wr ? GET_DATA : GET_CSUM;
`else
                        state  <= is_wr ? GET_DATA : EXEC;
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= IDLE;
                    end
                end
                GET_DATA: begin
                    if (accept) begin
`ifdef UART_CMD_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
                        data_q <= rx_data;
                        state  <= GET_CSUM;
`else
                        // Strobe is registered so it is high during the EXEC cycle.
                        if (addr_ok) begin
                            wr_stb  <= 1'b1;
                            wr_addr <= addr_q[3:0];
                            wr_data <= rx_data;
                        end
                        state <= EXEC;
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= IDLE;
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                GET_CSUM: begin
                    if (accept) begin
                        csum_bad_q <= (csum_q != rx_data);
                        if (is_wr && addr_ok && csum_q == rx_data) begin
                            wr_stb  <= 1'b1;
                            wr_addr <= addr_q[3:0];
                            wr_data <= data_q;
                        end
                        state <= EXEC;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= IDLE;
                    end
                end
`endif
                EXEC: begin
                    if (frame_err)  tx_data <= RSP_ERR;
                    else if (is_wr) tx_data <= RSP_OK;
                    else            tx_data <= rd_data;
                    tx_wr <= !tx_busy;
                    state <= SEND;
                end
                SEND: begin
                    if (tx_wr) begin
                        tx_wr      <= 1'b0;
                        wait_first <= 1'b1;
                        state      <= SEND_WAIT;
                    end else if (!tx_busy) begin
                        tx_wr <= 1'b1;
                    end
                end
                SEND_WAIT: begin
                    // The transmitter may raise busy one cycle late, so skip the first look.
                    wait_first <= 1'b0;
                    if (!wait_first && !tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: host byte source, transmitter
// model, register-bank reference model and reply scoreboard.
module tb_uart_cmd_responder;

    localparam int T_CYC = 20000;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy  = 1'b0;
    logic       tx_busy = 1'b0;
    logic       rx_clr;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [2:0] fsm_state;

    always #10 clk_50m = ~clk_50m;

    uart_cmd_responder dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .rx_clr    (rx_clr),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_busy   (tx_busy),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] host_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_txwr = 0, n_wrstb = 0, n_acc = 0;
    int exp_wrstb = 0, exp_replies = 0;
    int last_clr_cyc = 0, tx_wr_cyc = 0, wr_stb_cyc = 0;
    logic [3:0] last_wa = 4'h0;
    logic [7:0] last_wd = 8'h00;
    int tx_left = 0, tx_len = 3, gap = 0;
    bit hold_busy = 1'b0, drop_pending = 1'b0;
    logic [7:0] m_regs [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs, then update the transmitter and receiver models.
    task automatic tick();
        @(posedge clk_50m);
        #1;
        cyc++;
        if (tx_wr) begin
            got_q.push_back(tx_data);
            tx_wr_cyc = cyc;
            n_txwr++;
        end
        if (wr_stb) begin
            n_wrstb++;
            wr_stb_cyc = cyc;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (tx_left > 0) begin
            tx_busy = 1'b1;
            tx_left--;
        end else begin
            tx_busy = hold_busy;
        end
        if (tx_wr) tx_left = tx_len;
        if (rx_clr) begin
            n_acc++;
            last_clr_cyc = cyc;
            drop_pending = 1'b1;
        end else if (drop_pending) begin
            rx_rdy = 1'b0;
            drop_pending = 1'b0;
            gap = $urandom_range(0, 3);
        end else if (!rx_rdy) begin
            if (gap > 0) gap--;
            else if (host_q.size() > 0) begin
                rx_data = host_q.pop_front();
                rx_rdy = 1'b1;
            end
        end
    endtask

    // Queue a frame and record its expected reply from the register model.
    task automatic send_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] cs;
        host_q.push_back(op);
        cs = op;
        if (op == 8'h57 || op == 8'h52) begin
            host_q.push_back(addr);
            cs = cs ^ addr;
            if (op == 8'h57) begin
                host_q.push_back(data);
                cs = cs ^ data;
            end
`ifdef UART_CMD_CHECKSUM_EN
            host_q.push_back(cs);
`endif
        end
        exp_replies++;
        if (op == 8'h57) begin
            if (addr < 16) begin
                m_regs[addr[3:0]] = data;
                exp_wrstb++;
                exp_q.push_back(8'h4B);
            end else begin
                exp_q.push_back(8'h45);
            end
        end else if (op == 8'h52) begin
            exp_q.push_back((addr < 16) ? m_regs[addr[3:0]] : 8'h45);
        end else begin
            exp_q.push_back(8'h45);
        end
    endtask

    task automatic wait_reply(input string tag);
        int n;
        logic [7:0] g, e;
        n = 0;
        while (got_q.size() == 0 && n < 3000) begin
            tick();
            n++;
        end
        if (got_q.size() == 0) begin
            chk({tag, "_timeout"}, got_q.size(), 1);
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk(tag, g, e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || tx_busy || rx_rdy || tx_left > 0 || host_q.size() > 0) && n < 3000) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_acc(input int target, input string tag);
        int n;
        n = 0;
        while (n_acc < target && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, n_acc, target);
    endtask

    initial begin
        int base, t0, fall, sel;
        logic [7:0] op, addr, data;

        foreach (m_regs[i]) m_regs[i] = 8'h00;
        repeat (3) tick();
        chk("rst_rx_clr", rx_clr, 0);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_state", fsm_state, 0);
        rst_n = 1'b1;

        // Directed write then reads, with latency checks.
        wait_idle();
        send_frame(8'h57, 8'h03, 8'hA5);
        wait_reply("wr3_reply");
        chk("wr3_latency", tx_wr_cyc - last_clr_cyc, 1);
        chk("wr3_stb_cycle", wr_stb_cyc, last_clr_cyc);
        chk("wr3_stb_count", n_wrstb, exp_wrstb);
        chk("wr3_addr", last_wa, 4'h3);
        chk("wr3_data", last_wd, 8'hA5);

        wait_idle();
        send_frame(8'h52, 8'h03, 8'h00);
        wait_reply("rd3_reply");
        chk("rd3_latency", tx_wr_cyc - last_clr_cyc, 1);
        send_frame(8'h52, 8'h04, 8'h00);
        wait_reply("rd4_reply");

        wait_idle();
        send_frame(8'h41, 8'h00, 8'h00);
        wait_reply("badop_reply");
        chk("badop_latency", tx_wr_cyc - last_clr_cyc, 0);
        send_frame(8'h52, 8'h10, 8'h00);
        wait_reply("badaddr_rd_reply");
        send_frame(8'h57, 8'h10, 8'h5A);
        wait_reply("badaddr_wr_reply");
        chk("badaddr_no_stb", n_wrstb, exp_wrstb);

        // Truncated write frame must be abandoned silently.
        wait_idle();
        base = n_acc;
        host_q.push_back(8'h57);
        host_q.push_back(8'h02);
        wait_acc(base + 2, "tmo_bytes_taken");
        t0 = last_clr_cyc;
        while (cyc < t0 + T_CYC - 3) tick();
        chk("tmo_busy_before", busy, 1);
        while (cyc < t0 + T_CYC + 1) tick();
        chk("tmo_busy_after", busy, 0);
        chk("tmo_no_reply", got_q.size(), 0);
        chk("tmo_no_stb", n_wrstb, exp_wrstb);
        send_frame(8'h52, 8'h02, 8'h00);
        wait_reply("tmo_rd2_reply");

        // Transmitter held busy: one delayed tx_wr, queued frame parsed afterwards.
        wait_idle();
        hold_busy = 1'b1;
        tx_busy = 1'b1;
        base = n_txwr;
        send_frame(8'h52, 8'h03, 8'h00);
        repeat (100) tick();
        send_frame(8'h57, 8'h07, 8'h3C);
        repeat (400) tick();
        chk("hold_no_tx", n_txwr, base);
        chk("hold_byte_pending", rx_rdy, 1);
        hold_busy = 1'b0;
        tx_busy = 1'b0;
        fall = cyc;
        wait_reply("hold_rd_reply");
        chk("hold_tx_cycle", tx_wr_cyc, fall + 1);
        chk("hold_tx_once", n_txwr, base + 1);
        wait_reply("hold_wr_reply");
        chk("hold_wr_stb", n_wrstb, exp_wrstb);

        // Randomized frames, sometimes two queued back to back.
        for (int k = 0; k < 40; k++) begin
            tx_len = $urandom_range(1, 12);
            for (int f = 0; f < 2; f++) begin
                sel = $urandom_range(0, 9);
                addr = 8'($urandom_range(0, 19));
                data = 8'($urandom);
                if (sel < 4) op = 8'h57;
                else if (sel < 8) op = 8'h52;
                else begin
                    op = 8'($urandom);
                    while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                end
                send_frame(op, addr, data);
                if ($urandom_range(0, 1) == 0) break;
            end
            while (exp_q.size() > 0) wait_reply("rand_reply");
            chk("rand_stb_count", n_wrstb, exp_wrstb);
        end

`ifdef UART_CMD_CHECKSUM_EN
        wait_idle();
        host_q.push_back(8'h57); host_q.push_back(8'h01);
        host_q.push_back(8'h22); host_q.push_back(8'h74);
        m_regs[1] = 8'h22; exp_wrstb++; exp_replies++; exp_q.push_back(8'h4B);
        wait_reply("csum_ok_reply");
        host_q.push_back(8'h57); host_q.push_back(8'h01);
        host_q.push_back(8'h33); host_q.push_back(8'h00);
        exp_replies++; exp_q.push_back(8'h45);
        wait_reply("csum_bad_reply");
        chk("csum_bad_no_stb", n_wrstb, exp_wrstb);
        send_frame(8'h52, 8'h01, 8'h00);
        wait_reply("csum_rd1_reply");
`endif

        chk("total_tx_wr", n_txwr, exp_replies);

        // Reset while a reply waits on a busy transmitter: it is never sent.
        wait_idle();
        hold_busy = 1'b1;
        tx_busy = 1'b1;
        base = n_txwr;
        host_q.push_back(8'h52);
`ifndef UART_CMD_CHECKSUM_EN
        host_q.push_back(8'h03);
        wait_acc(n_acc + 2, "rstsend_bytes_taken");
`else
        host_q.push_back(8'h03);
        host_q.push_back(8'h51);
        wait_acc(n_acc + 3, "rstsend_bytes_taken");
`endif
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("rstsend_busy", busy, 0);
        chk("rstsend_tx_wr", tx_wr, 0);
        chk("rstsend_tx_data", tx_data, 0);
        rst_n = 1'b1;
        hold_busy = 1'b0;
        tx_busy = 1'b0;
        rx_rdy = 1'b0;
        drop_pending = 1'b0;
        repeat (50) tick();
        chk("rstsend_no_tx", n_txwr, base);
        foreach (m_regs[i]) m_regs[i] = 8'h00;

        // Reset in the middle of a write frame.
        base = n_acc;
        host_q.push_back(8'h57);
        host_q.push_back(8'h09);
        wait_acc(base + 2, "rstframe_bytes_taken");
        rst_n = 1'b0;
        tick();
        chk("rstframe_busy", busy, 0);
        chk("rstframe_wr_addr", wr_addr, 0);
        chk("rstframe_wr_data", wr_data, 0);
        chk("rstframe_rx_clr", rx_clr, 0);
        rst_n = 1'b1;
        host_q.delete();
        rx_rdy = 1'b0;
        drop_pending = 1'b0;
        tick();
        base = n_wrstb;
        send_frame(8'h52, 8'h03, 8'h00);
        wait_reply("rstframe_rd3_reply");
        chk("rstframe_no_stb", n_wrstb, base);
        repeat (20) tick();
        chk("no_extra_replies", got_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
